// File: rtl/dual_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dual_bus_pkg
// Purpose  : Shared types and limits for the dual-bus request responder.
// Revision : 1.0 - initial release
// ============================================================================
package dual_bus_pkg;

    localparam int ACK_DLY_MAX = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        CH1 = 1'b0,
        CH2 = 1'b1
    } chan_t;

endpackage
`default_nettype wire

// File: rtl/rise_det.sv
`default_nettype none
// ============================================================================
// Module   : rise_det
// Purpose  : Registers a request level and flags its rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module rise_det (
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    output logic o_rise
);

    logic r_req_q;

    // Clearing on reset makes a request held across reset release count as new.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req_q <= 1'b0;
        end else begin
            r_req_q <= i_req;
        end
    end

    assign o_rise = i_req & ~r_req_q;

endmodule
`default_nettype wire

// File: rtl/dual_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : dual_bus_responder
// Purpose  : Services one of two level-held request buses with a delayed ack.
//            Optional abort pulse output enabled by DUAL_BUS_ABORT_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dual_bus_responder
    import dual_bus_pkg::*;
#(
    parameter int ACK_DLY = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic bus_select,
    input  logic req1,
    input  logic req2,
    output logic ack1,
    output logic ack2,
    output logic busy,
    output logic done
`ifdef DUAL_BUS_ABORT_ERR_EN
    ,
    output logic err
`endif
);

    generate
        if (ACK_DLY < 0 || ACK_DLY > ACK_DLY_MAX) begin : g_ack_dly_check
            $fatal(1, "dual_bus_responder: ACK_DLY out of range 0..ACK_DLY_MAX");
        end
    endgenerate

    localparam logic [2:0] c_ack_dly = 3'(ACK_DLY);

    logic       w_rise1;
    logic       w_rise2;
    logic       w_req_ch;
    state_t     r_state;
    chan_t      r_ch;
    logic [2:0] r_cnt;
    logic       r_ack1;
    logic       r_ack2;
    logic       r_busy;
    logic       r_done;
`ifdef DUAL_BUS_ABORT_ERR_EN
    logic       r_err;
`endif

    rise_det u_rise1 (
        .clk    (clk),
        .reset  (reset),
        .i_req  (req1),
        .o_rise (w_rise1)
    );

    rise_det u_rise2 (
        .clk    (clk),
        .reset  (reset),
        .i_req  (req2),
        .o_rise (w_rise2)
    );

    assign w_req_ch = (r_ch == CH1) ? req1 : req2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ch    <= CH1;
            r_cnt   <= 3'd0;
            r_ack1  <= 1'b0;
            r_ack2  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef DUAL_BUS_ABORT_ERR_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef DUAL_BUS_ABORT_ERR_EN
            r_err  <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    // Only the selected bus may start a transaction; the other rise is dropped.
                    if (!bus_select && w_rise1) begin
                        r_state <= WAIT;
                        r_ch    <= CH1;
                        r_cnt   <= c_ack_dly;
                        r_busy  <= 1'b1;
                    end else if (bus_select && w_rise2) begin
                        r_state <= WAIT;
                        r_ch    <= CH2;
                        r_cnt   <= c_ack_dly;
                        r_busy  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (!w_req_ch) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
`ifdef DUAL_BUS_ABORT_ERR_EN
                        r_err   <= 1'b1;
`endif
                    end else if (r_cnt == 3'd0) begin
                        r_state <= ACK;
                        r_ack1  <= (r_ch == CH1);
                        r_ack2  <= (r_ch == CH2);
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                ACK: begin
                    if (!w_req_ch) begin
                        r_state <= DONE;
                        r_ack1  <= 1'b0;
                        r_ack2  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ack1  <= 1'b0;
                    r_ack2  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ack1 = r_ack1;
    assign ack2 = r_ack2;
    assign busy = r_busy;
    assign done = r_done;
`ifdef DUAL_BUS_ABORT_ERR_EN
    assign err  = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dual_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_bus_responder
// Purpose  : Self-checking bench; two responders (ACK_DLY 2 and 5) share stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dual_bus_responder;

    logic clk = 1'b0;
    logic rst_n;
    logic bus_select;
    logic req1;
    logic req2;
    logic ack1_a, ack2_a, busy_a, done_a, err_a;
    logic ack1_b, ack2_b, busy_b, done_b, err_b;
    int   errors = 0;
    int   checks = 0;
    int   edge_n = 0;

`ifdef DUAL_BUS_ABORT_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
    assign err_a = 1'b0;
    assign err_b = 1'b0;
`endif

    always #5 clk = ~clk;

    dual_bus_responder #(.ACK_DLY(2)) u_dut_a (
        .clk        (clk),
        .reset      (rst_n),
        .bus_select (bus_select),
        .req1       (req1),
        .req2       (req2),
        .ack1       (ack1_a),
        .ack2       (ack2_a),
        .busy       (busy_a),
        .done       (done_a)
`ifdef DUAL_BUS_ABORT_ERR_EN
        ,
        .err        (err_a)
`endif
    );

    dual_bus_responder #(.ACK_DLY(5)) u_dut_b (
        .clk        (clk),
        .reset      (rst_n),
        .bus_select (bus_select),
        .req1       (req1),
        .req2       (req2),
        .ack1       (ack1_b),
        .ack2       (ack2_b),
        .busy       (busy_b),
        .done       (done_b)
`ifdef DUAL_BUS_ABORT_ERR_EN
        ,
        .err        (err_b)
`endif
    );

    // Transaction-level reference: capture edge time, ack once latency elapsed.
    bit m_active [2];
    bit m_acked  [2];
    bit m_done   [2];
    bit m_err    [2];
    int m_ch     [2];
    int m_tcap   [2];
    bit p1, p2;

    function automatic int dly(int i);
        return (i == 0) ? 2 : 5;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0; m_acked[i] = 1'b0; m_done[i] = 1'b0;
            m_err[i] = 1'b0; m_ch[i] = 1; m_tcap[i] = 0;
        end
        p1 = 1'b0; p2 = 1'b0;
    endtask

    task automatic model_edge();
        bit r1, r2, rq;
        r1 = req1 && !p1;
        r2 = req2 && !p2;
        for (int i = 0; i < 2; i++) begin
            m_err[i] = 1'b0;
            if (m_done[i]) begin
                m_done[i] = 1'b0;
            end else if (!m_active[i]) begin
                if ((!bus_select && r1) || (bus_select && r2)) begin
                    m_active[i] = 1'b1;
                    m_acked[i]  = 1'b0;
                    m_ch[i]     = bus_select ? 2 : 1;
                    m_tcap[i]   = edge_n;
                end
            end else begin
                rq = (m_ch[i] == 1) ? req1 : req2;
                if (!rq) begin
                    m_active[i] = 1'b0;
                    if (m_acked[i]) m_done[i] = 1'b1;
                    else            m_err[i]  = ERR_EN;
                    m_acked[i] = 1'b0;
                end else if (!m_acked[i] && (edge_n - m_tcap[i] >= 1 + dly(i))) begin
                    m_acked[i] = 1'b1;
                end
            end
        end
        p1 = req1;
        p2 = req2;
        edge_n++;
    endtask

    function automatic logic [4:0] exp_vec(int i);
        return {m_active[i] && m_acked[i] && (m_ch[i] == 1),
                m_active[i] && m_acked[i] && (m_ch[i] == 2),
                m_active[i] || m_done[i], m_done[i], m_err[i]};
    endfunction

    function automatic logic [4:0] obs_vec(int i);
        return (i == 0) ? {ack1_a, ack2_a, busy_a, done_a, err_a}
                        : {ack1_b, ack2_b, busy_b, done_b, err_b};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus_select = 1'b0; req1 = 1'b0; req2 = 1'b0;
        model_reset();
        #1;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_vec(i) !== 5'b0) begin
                    errors++;
                    $display("FAIL reset_state dut%0d: got %b want %b", i, obs_vec(i), 5'b0);
                end
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_basic();
        int lat_a, lat_b;
        lat_a = -1; lat_b = -1;
        bus_select = 1'b0;
        req1 = 1'b1;
        for (int j = 0; j <= 12; j++) begin
            tick();
            if (lat_a < 0 && ack1_a) lat_a = j;
            if (lat_b < 0 && ack1_b) lat_b = j;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL basic dut%0d edge %0d: got %b want %b", i, edge_n, obs_vec(i), exp_vec(i));
                end
            end
        end
        checks++;
        if (lat_a !== 3 || lat_b !== 6) begin
            errors++;
            $display("FAIL basic_latency: got a=%0d b=%0d want a=3 b=6", lat_a, lat_b);
        end
        req1 = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL basic_done dut%0d edge %0d: got %b want %b", i, edge_n, obs_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        bus_select = 1'b1;
        req1 = 1'b1; req2 = 1'b1;
        for (int j = 0; j < 13; j++) begin
            if (j == 10) begin req1 = 1'b0; req2 = 1'b0; end
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL simultaneous dut%0d edge %0d: got %b want %b", i, edge_n, obs_vec(i), exp_vec(i));
                end
            end
            checks++;
            if (ack1_a !== 1'b0 || ack1_b !== 1'b0) begin
                errors++;
                $display("FAIL simultaneous_ack1 edge %0d: got %b%b want 00", edge_n, ack1_a, ack1_b);
            end
        end
    endtask

    task automatic test_abort();
        bit saw_done;
        saw_done = 1'b0;
        bus_select = 1'b0;
        req1 = 1'b1;
        for (int j = 0; j < 7; j++) begin
            if (j == 3) req1 = 1'b0;
            tick();
            if (done_a || done_b || ack1_a || ack1_b) saw_done = 1'b1;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL abort dut%0d edge %0d: got %b want %b", i, edge_n, obs_vec(i), exp_vec(i));
                end
            end
            if (j == 3) begin
                checks++;
                if (busy_a !== 1'b0 || busy_b !== 1'b0 || err_a !== ERR_EN || err_b !== ERR_EN) begin
                    errors++;
                    $display("FAIL abort_exit: got busy=%b%b err=%b%b want busy=00 err=%b%b",
                             busy_a, busy_b, err_a, err_b, ERR_EN, ERR_EN);
                end
            end
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_ack_done: got %b want 0", saw_done);
        end
    endtask

    task automatic test_select_toggle();
        int lat_a, lat_b;
        lat_a = -1; lat_b = -1;
        bus_select = 1'b0;
        req1 = 1'b1;
        for (int j = 0; j <= 9; j++) begin
            tick();
            if (lat_a < 0 && ack1_a) lat_a = j;
            if (lat_b < 0 && ack1_b) lat_b = j;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL select_toggle dut%0d edge %0d: got %b want %b", i, edge_n, obs_vec(i), exp_vec(i));
                end
            end
            checks++;
            if (ack2_a !== 1'b0 || ack2_b !== 1'b0) begin
                errors++;
                $display("FAIL select_toggle_ack2 edge %0d: got %b%b want 00", edge_n, ack2_a, ack2_b);
            end
            bus_select = ~bus_select;
            req2 = 1'($urandom_range(0, 1));
        end
        checks++;
        if (lat_a !== 3 || lat_b !== 6) begin
            errors++;
            $display("FAIL select_toggle_latency: got a=%0d b=%0d want a=3 b=6", lat_a, lat_b);
        end
        req1 = 1'b0; req2 = 1'b0; bus_select = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        int lat_a, lat_b;
        lat_a = -1; lat_b = -1;
        bus_select = 1'b0;
        req1 = 1'b1;
        repeat (5) tick();
        checks++;
        if (ack1_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_setup: got ack1=%b want 1", ack1_a);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_vec(i) !== 5'b0) begin
                errors++;
                $display("FAIL reset_mid_async dut%0d: got %b want %b", i, obs_vec(i), 5'b0);
            end
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j <= 8; j++) begin
            tick();
            if (lat_a < 0 && ack1_a) lat_a = j;
            if (lat_b < 0 && ack1_b) lat_b = j;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL reset_mid dut%0d edge %0d: got %b want %b", i, edge_n, obs_vec(i), exp_vec(i));
                end
            end
        end
        checks++;
        if (lat_a !== 3 || lat_b !== 6) begin
            errors++;
            $display("FAIL reset_mid_latency: got a=%0d b=%0d want a=3 b=6", lat_a, lat_b);
        end
        req1 = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_random();
        for (int j = 0; j < 800; j++) begin
            if ($urandom_range(0, 7) == 0) req1 = ~req1;
            if ($urandom_range(0, 7) == 0) req2 = ~req2;
            if ($urandom_range(0, 5) == 0) bus_select = ~bus_select;
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL random dut%0d edge %0d: got %b want %b", i, edge_n, obs_vec(i), exp_vec(i));
                end
            end
            checks++;
            if ((ack1_a && ack2_a) || (ack1_b && ack2_b)) begin
                errors++;
                $display("FAIL random_ack_exclusive edge %0d: got a=%b%b b=%b%b", edge_n, ack1_a, ack2_a, ack1_b, ack2_b);
            end
        end
        req1 = 1'b0; req2 = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_simultaneous();
        test_abort();
        test_select_toggle();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
